// File: rtl/fetch_prefetch.sv
// fetch_prefetch: PC owner issuing pipelined imem reads into a prefetch queue with redirect flush
module fetch_prefetch #(
  parameter int ADDRESS = 32,
  parameter int INSTRUCTION = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDRESS-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDRESS-1:0]     imem_addr,
  output logic                   imem_we_re,
  output logic [3:0]             imem_mask,
  input  logic                   imem_ready,
  input  logic                   imem_valid,
  input  logic [INSTRUCTION-1:0] imem_rdata,
  input  logic                   redirect,
  input  logic [ADDRESS-1:0]     redirect_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTRUCTION-1:0] instr,
  output logic [ADDRESS-1:0]     instr_pc
);
  localparam int P = $clog2(DEPTH);
  localparam int W = P + 1;
  localparam int E = INSTRUCTION + ADDRESS;

  logic [ADDRESS-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [W-1:0] count_q, count_d, outstanding_q, outstanding_d, drop_q, drop_d;
  logic [P-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [E-1:0] mem_q [DEPTH];
  logic fire, push, pop;

  // credit rule: never have more queued plus in-flight words than queue slots
  assign imem_req = !rst && !redirect && ({1'b0, count_q} + {1'b0, outstanding_q} < (W+1)'(DEPTH));
  assign imem_addr = pc_q;
  assign imem_we_re = 1'b0;
  assign imem_mask = 4'b1111;
  assign instr_valid = (count_q != '0) && !redirect;
  assign instr = mem_q[rd_q][E-1:ADDRESS];
  assign instr_pc = mem_q[rd_q][ADDRESS-1:0];

  // next-state: redirect wins, turning every still-pending request into one to drop
  always_comb begin
    fire = imem_req && imem_ready;
    push = imem_valid && (drop_q == '0) && !redirect;
    pop = instr_valid && instr_ready;
    pc_d = redirect ? redirect_addr : fire ? pc_q + ADDRESS'(4) : pc_q;
    resp_pc_d = redirect ? redirect_addr : push ? resp_pc_q + ADDRESS'(4) : resp_pc_q;
    outstanding_d = outstanding_q + W'(fire) - W'(imem_valid);
    drop_d = redirect ? outstanding_q - W'(imem_valid) : drop_q - W'(imem_valid && (drop_q != '0));
    count_d = redirect ? '0 : count_q + W'(push) - W'(pop);
    wr_d = redirect ? rd_q : wr_q + P'(push);
    rd_d = rd_q + P'(pop);
  end

  // control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      count_q <= '0;
      outstanding_q <= '0;
      drop_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      pc_q <= pc_d;
      resp_pc_q <= resp_pc_d;
      count_q <= count_d;
      outstanding_q <= outstanding_d;
      drop_q <= drop_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  // queue storage, tagged with the PC of each kept response
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {imem_rdata, resp_pc_q};
  end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed checks of streaming, back-pressure, redirect, wrap and async reset
module tb_fetch_prefetch;
  logic clk = 0, rst = 1;
  logic imem_ready = 1, imem_valid = 0, redirect = 0, instr_ready = 0;
  logic [31:0] imem_rdata = 0, redirect_addr = 0;
  logic imem_req, imem_we_re, instr_valid;
  logic [3:0] imem_mask;
  logic [31:0] imem_addr, instr, instr_pc;
  logic w_req, w_we, w_iv;
  logic [3:0] w_mask;
  logic [31:0] w_addr, w_instr, w_pc;
  int n = 0, errs = 0, cyc = 0, lat = 1;
  logic [31:0] q_addr [$];
  int q_due [$];

  fetch_prefetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_we_re(imem_we_re),
    .imem_mask(imem_mask), .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_addr(redirect_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  fetch_prefetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_we_re(w_we),
    .imem_mask(w_mask), .imem_ready(1'b1), .imem_valid(1'b0), .imem_rdata(32'h0),
    .redirect(1'b0), .redirect_addr(32'h0), .instr_valid(w_iv),
    .instr_ready(1'b0), .instr(w_instr), .instr_pc(w_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    logic acc, v;
    logic [31:0] a;
    acc = imem_req && imem_ready;
    a = imem_addr;
    v = imem_valid;
    @(negedge clk);
    if (v) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (acc) begin
      q_addr.push_back(a);
      q_due.push_back(cyc + lat);
    end
    cyc++;
    imem_valid = (q_addr.size() != 0) && (q_due[0] <= cyc);
    imem_rdata = imem_valid ? q_addr[0] : 32'h0;
    #1;
  endtask

  task automatic flush_mem;
    q_addr.delete();
    q_due.delete();
    imem_valid = 0;
    imem_rdata = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    redirect = 0;
    flush_mem();
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_iv", 32'(instr_valid), 0);
    rst = 0;
    cyc = 0;
    #1;
  endtask

  initial begin
    logic [31:0] e;
    // streaming with 1-cycle memory; the wrap instance runs alongside
    instr_ready = 1;
    lat = 1;
    do_reset();
    chk("we_re", 32'(imem_we_re), 0);
    chk("mask", 32'(imem_mask), 32'hF);
    for (int i = 0; i < 6; i++) begin
      chk("stream_req", 32'(imem_req), 1);
      chk("stream_addr", imem_addr, 32'(4 * i));
      e = 32'hFFFF_FFF8 + 32'(4 * i);
      if (i < 4) chk("wrap_addr", w_addr, e);
      if (i == 4) chk("wrap_stall", 32'(w_req), 0);
      if (i >= 2) begin
        chk("stream_iv", 32'(instr_valid), 1);
        chk("stream_pc", instr_pc, 32'(4 * (i - 2)));
        chk("stream_instr", instr, 32'(4 * (i - 2)));
      end else chk("stream_iv0", 32'(instr_valid), 0);
      tick();
    end
    // back-pressure: four requests then stall until a pop
    instr_ready = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      chk("bp_req", 32'(imem_req), i < 4 ? 1 : 0);
      if (i < 4) chk("bp_addr", imem_addr, 32'(4 * i));
      tick();
    end
    instr_ready = 1;
    #1;
    chk("bp_head_iv", 32'(instr_valid), 1);
    chk("bp_head_pc", instr_pc, 0);
    tick();
    chk("bp_resume_req", 32'(imem_req), 1);
    chk("bp_resume_addr", imem_addr, 32'h10);
    chk("bp_next_pc", instr_pc, 4);
    // redirect with two requests in flight on 3-cycle memory
    lat = 3;
    do_reset();
    tick();
    tick();
    redirect = 1;
    redirect_addr = 32'h100;
    #1;
    chk("rd_req_off", 32'(imem_req), 0);
    chk("rd_iv_off", 32'(instr_valid), 0);
    tick();
    redirect = 0;
    #1;
    chk("rd_new_addr", imem_addr, 32'h100);
    for (int i = 0; i < 4; i++) begin
      chk("rd_drained", 32'(instr_valid), 0);
      tick();
    end
    chk("rd_first_iv", 32'(instr_valid), 1);
    chk("rd_first_pc", instr_pc, 32'h100);
    chk("rd_first_instr", instr, 32'h100);
    tick();
    chk("rd_second_pc", instr_pc, 32'h104);
    // redirect coinciding with a response and a pending pop
    lat = 1;
    do_reset();
    tick();
    tick();
    chk("co_resp_present", 32'(imem_valid), 1);
    redirect = 1;
    redirect_addr = 32'h200;
    #1;
    chk("co_iv_off", 32'(instr_valid), 0);
    chk("co_req_off", 32'(imem_req), 0);
    tick();
    redirect = 0;
    #1;
    chk("co_empty", 32'(instr_valid), 0);
    chk("co_addr", imem_addr, 32'h200);
    tick();
    chk("co_empty2", 32'(instr_valid), 0);
    tick();
    chk("co_first_iv", 32'(instr_valid), 1);
    chk("co_first_pc", instr_pc, 32'h200);
    // asynchronous reset with a full queue
    instr_ready = 0;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("ar_full_iv", 32'(instr_valid), 1);
    chk("ar_full_pc", instr_pc, 0);
    #2;
    rst = 1;
    flush_mem();
    #1;
    chk("ar_iv_now", 32'(instr_valid), 0);
    chk("ar_req_now", 32'(imem_req), 0);
    @(negedge clk);
    rst = 0;
    cyc = 0;
    instr_ready = 1;
    #1;
    chk("ar_restart_req", 32'(imem_req), 1);
    chk("ar_restart_addr", imem_addr, 0);
    tick();
    tick();
    chk("ar_restart_pc", instr_pc, 0);
    chk("ar_restart_iv", 32'(instr_valid), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
